microseq_next_state: RTL
========================

Name: microseq_next_state

Overview:
- Next-state sequencer of the microprogrammed control unit; sits directly downstream of the instruction encoder.
- Each cycle it selects the next control-store state from four sources:
  - the encoder's 7-bit dispatch state;
  - the jump field of the current microinstruction;
  - the incremented current state;
  - the fetch state.
- Selection is made under a microcoded condition (memory-op-complete, ARM condition pass, constant).
- The registered state drives the control-store address.

Parameters:
- AW, 7, state/address width (matches encoder output width).
- FETCH_STATE, 7'd1, state entered on ns_sel=RESTART and on condition-fail abort.
- RESET_STATE, 7'd0, state held in reset.
- ABORT_STATE, 7'd91, undefined/abort handler state (same code the encoder emits for unknown opcodes).
- TIMEOUT_CYCLES, 16, MOC wait limit (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enc_in  in  AW  dispatch state from encoder.
- cr_addr  in  AW  jump-address field of current microinstruction.
- ns_sel  in  3  next-state mode field of current microinstruction.
- cond_sel  in  2  condition source: 00 moc, 01 cond_pass, 10 const 1, 11 const 0.
- inv  in  1  invert selected condition.
- moc  in  1  memory operation complete.
- cond_pass  in  1  ARM condition-code check result for current instruction.
- state  out  AW  registered current state / control-store address.
- dispatch  out  1  registered; high for the cycle after a state was loaded from enc_in.
- timeout_err  out  1  registered one-cycle pulse; optional feature only, else tied 0.

Behaviour:
- One clock; reset is asynchronous and active-low. Ports are named clk and reset_n.
- Reset values (async on reset_n low): state=RESET_STATE, dispatch=0, timeout_err=0, wait counter=0.
- First rising edge after reset_n deasserts evaluates normally from RESET_STATE.
- Condition: c = mux(cond_sel) XOR inv. Combinational, same cycle.
- inc = state+1, modulo 2^AW; 127 wraps to 0, no flag.
- Next state, registered on every rising clk (one-cycle latency, no stall input):
  - 000 DISPATCH: enc_in.
  - 001 JUMP: cr_addr.
  - 010 INC: inc.
  - 011 RESTART: FETCH_STATE.
  - 100 CJUMP: c ? cr_addr : inc.
  - 101 CABORT: c ? inc : FETCH_STATE. Used for condition-fail skip.
  - 110 WAIT: c ? inc : state. Used for MOC hold.
  - 111 CDISP: c ? cr_addr : enc_in.
- dispatch: next value = 1 iff the selected source is enc_in (DISPATCH, or CDISP with c=0).
- enc_in = 0 (encoder's all-zero-instruction code) is dispatched like any other value; no special case.
- X/unknown ns_sel is not decoded; a default branch selects FETCH_STATE.

Optional Feature:
- Macro: MICROSEQ_MOC_TIMEOUT_EN.
- Defined:
  - Wait counter increments each cycle that ns_sel=WAIT and c=0.
  - Counter clears on any cycle where that is not true.
  - When the counter reaches TIMEOUT_CYCLES-1 while still waiting:
    - next state = ABORT_STATE (overrides WAIT hold);
    - timeout_err pulses 1 for one cycle;
    - counter clears.
  - If c=1 on the limit cycle, the normal inc is taken; no error.
- Undefined:
  - No counter; WAIT holds indefinitely.
  - timeout_err is constant 0.

Decomposition:
- Package microseq_pkg:
  - ns_sel encodings NS_DISPATCH..NS_CDISP;
  - cond_sel encodings COND_MOC, COND_PASS, COND_ONE, COND_ZERO;
  - AW default.
- One sub-module: microseq_incrementer (AW-bit +1, wrap). Keep the mux and registers in the top.

Test Plan:
- Reset: hold reset_n=0 with any ns_sel → state=0, dispatch=0. Assert reset_n=0 mid-WAIT → state=0 immediately, no clk needed.
- Dispatch: state=1, ns_sel=000, enc_in=7'b0101011 → next state=43, dispatch=1 for one cycle. Then ns_sel=010 → 44, dispatch=0.
- Wrap/jump: state=127, ns_sel=010 → 0. Then ns_sel=001, cr_addr=40 → 40.
- MOC wait: ns_sel=110, cond_sel=00, moc=0 for 3 cycles → state unchanged. moc=1 → state+1 next edge. Same with inv=1: moc=1 holds, moc=0 advances.
- Condition abort: ns_sel=101, cond_sel=01, cond_pass=0 → state=FETCH_STATE(1); cond_pass=1 → inc. CDISP with c=0 → enc_in, dispatch=1.
- With MICROSEQ_MOC_TIMEOUT_EN, TIMEOUT_CYCLES=16: WAIT with moc=0 held → state hold for 15 edges, 16th edge state=91 and timeout_err=1 for one cycle. moc=1 on the 16th cycle → inc, timeout_err=0.

Source files
------------

// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer next-state logic: next-state modes,
// condition sources and the default state width.
package microseq_pkg;

   localparam int AW_DEFAULT = 7;

   typedef enum logic [2:0] {
      NS_DISPATCH = 3'b000,
      NS_JUMP     = 3'b001,
      NS_INC      = 3'b010,
      NS_RESTART  = 3'b011,
      NS_CJUMP    = 3'b100,
      NS_CABORT   = 3'b101,
      NS_WAIT     = 3'b110,
      NS_CDISP    = 3'b111
   } nsSel_e;

   typedef enum logic [1:0] {
      COND_MOC  = 2'b00,
      COND_PASS = 2'b01,
      COND_ONE  = 2'b10,
      COND_ZERO = 2'b11
   } condSel_e;

endpackage

// File: rtl/microseq_incrementer.sv
// AW-bit state incrementer; the all-ones state wraps to zero with no carry out.
module microseq_incrementer
   import microseq_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input  logic [AW-1:0] cur,
   output logic [AW-1:0] inc
);

   assign inc = cur + AW'(1);

endmodule

// File: rtl/microseq_next_state.sv
// Next-state sequencer of the microprogrammed control unit: picks the next
// control-store state from dispatch, jump, increment or fetch under a microcoded
// condition. Optional MOC wait timeout is enabled with `define MICROSEQ_MOC_TIMEOUT_EN.
module microseq_next_state
   import microseq_pkg::*;
#(
   parameter int            AW          = AW_DEFAULT,
   parameter logic [AW-1:0] FETCH_STATE = AW'(1),
   parameter logic [AW-1:0] RESET_STATE = AW'(0)
`ifdef MICROSEQ_MOC_TIMEOUT_EN
   ,
   parameter logic [AW-1:0] ABORT_STATE    = AW'(91),
   parameter int            TIMEOUT_CYCLES = 16
`endif
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] enc_in,
   input  logic [AW-1:0] cr_addr,
   input  logic [2:0]    ns_sel,
   input  logic [1:0]    cond_sel,
   input  logic          inv,
   input  logic          moc,
   input  logic          cond_pass,
   output logic [AW-1:0] state,
   output logic          dispatch,
   output logic          timeout_err
);

   logic [AW-1:0] incState;
   logic [AW-1:0] nextState;
   logic [AW-1:0] stateD;
   logic          rawCond;
   logic          cond;
   logic          fromEnc;

   microseq_incrementer #(.AW(AW)) uIncrementer (
      .cur (state),
      .inc (incState)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      rawCond   = 1'b0;
      nextState = FETCH_STATE;
      fromEnc   = 1'b0;

      case (condSel_e'(cond_sel))
         COND_MOC:  rawCond = moc;
         COND_PASS: rawCond = cond_pass;
         COND_ONE:  rawCond = 1'b1;
         COND_ZERO: rawCond = 1'b0;
         default:   rawCond = 1'b0;
      endcase
      cond = rawCond ^ inv;

      // Unknown ns_sel falls to the default branch and restarts at fetch.
      case (nsSel_e'(ns_sel))
         NS_DISPATCH: begin
            nextState = enc_in;
            fromEnc   = 1'b1;
         end
         NS_JUMP:    nextState = cr_addr;
         NS_INC:     nextState = incState;
         NS_RESTART: nextState = FETCH_STATE;
         NS_CJUMP:   nextState = cond ? cr_addr : incState;
         NS_CABORT:  nextState = cond ? incState : FETCH_STATE;
         NS_WAIT:    nextState = cond ? incState : state;
         NS_CDISP: begin
            nextState = cond ? cr_addr : enc_in;
            fromEnc   = ~cond;
         end
         default:    nextState = FETCH_STATE;
      endcase
   end

`ifdef MICROSEQ_MOC_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] waitCnt;
   logic          waiting;
   logic          timeoutHit;

   assign waiting    = (ns_sel == NS_WAIT) && !cond;
   assign timeoutHit = waiting && (waitCnt == CW'(TIMEOUT_CYCLES - 1));
   assign stateD     = timeoutHit ? ABORT_STATE : nextState;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         waitCnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= timeoutHit;
         waitCnt     <= (waiting && !timeoutHit) ? waitCnt + CW'(1) : '0;
      end
   end
`else
   assign stateD      = nextState;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         state    <= RESET_STATE;
         dispatch <= 1'b0;
      end else begin
         state    <= stateD;
         dispatch <= fromEnc;
      end
   end

endmodule
